// File: rtl/emmc_cmd_line_pkg.sv
// Shared types and constants for the eMMC CMD-line engine.
// Holds the response-kind enum, frame lengths and the serial CRC7 step.
package emmc_cmd_p;

  typedef enum logic [1:0] {
    RESP_NONE     = 2'd0,
    RESP_48       = 2'd1,
    RESP_48_NOCRC = 2'd2,
    RESP_136      = 2'd3
  } resp_kind_t;

  localparam logic [6:0] CRC7_POLY     = 7'h09;
  localparam int         CMD_FRAME_LEN = 48;
  localparam int         R48_LEN       = 48;
  localparam int         R136_LEN      = 136;
  localparam int         CNT_W         = 8;

  function automatic logic [6:0] crc7_step(logic [6:0] crc, logic din);
    return {crc[5:0], 1'b0} ^ (((din ^ crc[6]) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/emmc_cmd_line_if.sv
// Command/response handshake between the eMMC state machine (master)
// and the CMD-line engine (slave).
interface emmc_cmd_line_if;
  import emmc_cmd_p::*;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_idx;
  logic [31:0]  cmd_arg;
  resp_kind_t   resp_kind;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic [5:0]   resp_idx;
  logic         err_crc;
  logic         err_idx;
  logic         err_tmo;

  modport master (
    output cmd_valid, cmd_idx, cmd_arg, resp_kind,
    input  cmd_ready, resp_valid, resp_data, resp_idx, err_crc, err_idx, err_tmo
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_arg, resp_kind,
    output cmd_ready, resp_valid, resp_data, resp_idx, err_crc, err_idx, err_tmo
  );
endinterface

// File: rtl/emmc_cmd_line_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0); clr wins over en.
module emmc_crc7
  import emmc_cmd_p::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic [6:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) crc_q <= '0;
    else if (en)    crc_q <= crc7_step(crc_q, din);
  end

  assign crc = crc_q;
endmodule

// File: rtl/emmc_cmd_line.sv
// eMMC CMD-line engine: serializes a command with CRC7 and captures the response.
// Response CRC/index checking is built only with EMMC_CMD_RESP_CHECK_EN defined.
module emmc_cmd_line
  import emmc_cmd_p::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bit_stb,
  emmc_cmd_line_if.slave bus,
  output logic           cmd_o,
  output logic           cmd_oe,
  input  logic           cmd_i
);
  typedef enum logic [2:0] {S_NCC, S_IDLE, S_TX, S_TURN, S_WAIT_START, S_RX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] NCR_CNT   = CNT_W'(NCR_MAX);
  localparam logic [CNT_W-1:0] NCC_CNT   = CNT_W'(NCC_MIN);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(CMD_FRAME_LEN);
  localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(40);
  localparam logic [CNT_W-1:0] R48_CNT   = CNT_W'(R48_LEN);
  localparam logic [CNT_W-1:0] R136_CNT  = CNT_W'(R136_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, r_len;
  logic [39:0]      hdr_q, hdr_d;
  resp_kind_t       kind_q, kind_d;
  logic [126:0]     rx_q, rx_d;
  logic [127:0]     rx_next;
  logic             cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
  logic [127:0]     data_q, data_d;
  logic [5:0]       ridx_q, ridx_d;
  logic             ecrc_q, ecrc_d, eidx_q, eidx_d, etmo_q, etmo_d;
  logic             tx_crc_clr, tx_crc_en, tx_bit;
  logic [6:0]       tx_crc;
  logic             crc_err, idx_err;

  assign cnt_inc = cnt_q + 1'b1;
  assign rx_next = {rx_q, cmd_i};
  assign r_len   = (kind_q == RESP_136) ? R136_CNT : R48_CNT;
  // The first CRC bit comes straight from the generator; the rest are shifted out of hdr_q.
  assign tx_bit  = (cnt_q == HDR_CNT) ? tx_crc[6] : hdr_q[39];

  emmc_crc7 u_tx_crc (
    .clk(clk), .rst(rst), .clr(tx_crc_clr), .en(tx_crc_en), .din(hdr_q[39]), .crc(tx_crc)
  );

`ifdef EMMC_CMD_RESP_CHECK_EN
  logic [5:0] idx_q;
  logic [6:0] rx_crc;
  logic       rx_crc_clr, rx_crc_en;

  // The start bit is 0, so clearing on it is the same as folding it into the CRC.
  assign rx_crc_clr = (state_q == S_WAIT_START) && bit_stb && !cmd_i;
  assign rx_crc_en  = (state_q == S_RX) && bit_stb &&
                      ((kind_q == RESP_136) ? (cnt_q >= CNT_W'(8) && cnt_q < CNT_W'(128))
                                            : (cnt_q < HDR_CNT));

  emmc_crc7 u_rx_crc (
    .clk(clk), .rst(rst), .clr(rx_crc_clr), .en(rx_crc_en), .din(cmd_i), .crc(rx_crc)
  );

  always_ff @(posedge clk) begin
    if (rst)                                        idx_q <= '0;
    else if (state_q == S_IDLE && bus.cmd_valid)    idx_q <= bus.cmd_idx;
  end

  assign crc_err = (kind_q != RESP_48_NOCRC) && (rx_crc != rx_next[7:1]);
  assign idx_err = (kind_q == RESP_48) && (rx_next[45:40] != idx_q);
`else
  assign crc_err = 1'b0;
  assign idx_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    kind_d     = kind_q;
    rx_d       = rx_q;
    cmd_o_d    = cmd_o_q;
    cmd_oe_d   = cmd_oe_q;
    data_d     = data_q;
    ridx_d     = ridx_q;
    ecrc_d     = ecrc_q;
    eidx_d     = eidx_q;
    etmo_d     = etmo_q;
    tx_crc_clr = 1'b0;
    tx_crc_en  = 1'b0;
    case (state_q)
      S_NCC: if (bit_stb) begin
        cmd_o_d = 1'b1;
        if (cnt_inc == NCC_CNT) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      S_IDLE: begin
        cmd_oe_d = 1'b1;
        cmd_o_d  = 1'b1;
        if (bus.cmd_valid) begin
          hdr_d      = {2'b01, bus.cmd_idx, bus.cmd_arg};
          kind_d     = bus.resp_kind;
          tx_crc_clr = 1'b1;
          cnt_d      = '0;
          state_d    = S_TX;
        end
      end
      S_TX: if (bit_stb) begin
        cmd_o_d   = tx_bit;
        tx_crc_en = (cnt_q < HDR_CNT);
        hdr_d     = (cnt_q == HDR_CNT) ? {tx_crc[5:0], 1'b1, 33'b0} : {hdr_q[38:0], 1'b0};
        cnt_d     = cnt_inc;
        if (cnt_inc == FRAME_CNT) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end
      end
      S_TURN: if (bit_stb) begin
        if (kind_q == RESP_NONE) begin
          state_d = S_DONE;
          data_d  = '0;
          ridx_d  = '0;
          ecrc_d  = 1'b0;
          eidx_d  = 1'b0;
          etmo_d  = 1'b0;
        end else begin
          cmd_oe_d = 1'b0;
          cnt_d    = CNT_W'(1);
          state_d  = S_WAIT_START;
        end
      end
      S_WAIT_START: if (bit_stb) begin
        if (!cmd_i) begin
          rx_d    = '0;
          cnt_d   = CNT_W'(1);
          state_d = S_RX;
        end else if (cnt_inc == NCR_CNT) begin
          state_d  = S_DONE;
          cmd_oe_d = 1'b1;
          cmd_o_d  = 1'b1;
          data_d   = '0;
          ridx_d   = '0;
          ecrc_d   = 1'b0;
          eidx_d   = 1'b0;
          etmo_d   = 1'b1;
        end else cnt_d = cnt_inc;
      end
      S_RX: if (bit_stb) begin
        rx_d  = rx_next[126:0];
        cnt_d = cnt_inc;
        if (cnt_inc == r_len) begin
          state_d  = S_DONE;
          cmd_oe_d = 1'b1;
          cmd_o_d  = 1'b1;
          etmo_d   = 1'b0;
          ecrc_d   = crc_err;
          eidx_d   = idx_err;
          if (kind_q == RESP_136) begin
            data_d = {rx_next[127:1], 1'b0};
            ridx_d = 6'h3F;
          end else begin
            data_d = {96'b0, rx_next[39:8]};
            ridx_d = (kind_q == RESP_48_NOCRC) ? 6'h3F : rx_next[45:40];
          end
        end
      end
      S_DONE: begin
        state_d = S_NCC;
        cnt_d   = '0;
      end
      default: state_d = S_NCC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NCC;
      cnt_q    <= '0;
      hdr_q    <= '0;
      kind_q   <= RESP_NONE;
      rx_q     <= '0;
      cmd_o_q  <= 1'b1;
      cmd_oe_q <= 1'b0;
      data_q   <= '0;
      ridx_q   <= '0;
      ecrc_q   <= 1'b0;
      eidx_q   <= 1'b0;
      etmo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      kind_q   <= kind_d;
      rx_q     <= rx_d;
      cmd_o_q  <= cmd_o_d;
      cmd_oe_q <= cmd_oe_d;
      data_q   <= data_d;
      ridx_q   <= ridx_d;
      ecrc_q   <= ecrc_d;
      eidx_q   <= eidx_d;
      etmo_q   <= etmo_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = data_q;
  assign bus.resp_idx   = ridx_q;
  assign bus.err_crc    = ecrc_q;
  assign bus.err_idx    = eidx_q;
  assign bus.err_tmo    = etmo_q;
  assign cmd_o          = cmd_o_q;
  assign cmd_oe         = cmd_oe_q;
endmodule

// File: tb/tb_emmc_cmd_line.sv
// Self-checking bench for emmc_cmd_line: directed and random commands against a
// frame-level model (CRC7 by polynomial long division, response timing by bit count).
module tb_emmc_cmd_line;
  import emmc_cmd_p::*;

  localparam int NCR_MAX = 64;
  localparam int NCC_MIN = 8;
`ifdef EMMC_CMD_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, bit_stb, cmd_o, cmd_oe, cmd_i;
  emmc_cmd_line_if bus();

  emmc_cmd_line #(.NCR_MAX(NCR_MAX), .NCC_MIN(NCC_MIN)) dut (
    .clk(clk), .rst(rst), .bit_stb(bit_stb), .bus(bus),
    .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic         rv_seen, rv_after, s_ecrc, s_eidx, s_etmo;
  logic [127:0] s_data;
  logic [5:0]   s_idx;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit_stb pulse, then 1-2 idle clocks; the clock right after the strobe is observed too.
  task automatic stb();
    bit_stb = 1'b1;
    tick();
    bit_stb  = 1'b0;
    rv_seen  = bus.resp_valid;
    s_data   = bus.resp_data;
    s_idx    = bus.resp_idx;
    s_ecrc   = bus.err_crc;
    s_eidx   = bus.err_idx;
    s_etmo   = bus.err_tmo;
    tick();
    rv_after = bus.resp_valid;
    if ($urandom_range(1, 0) == 1) tick();
  endtask

  // Remainder of msg(x)*x^7 divided by x^7+x^3+1; msg occupies bits n-1..0, MSB first.
  function automatic logic [6:0] crc_ref(input logic [119:0] msg, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = n + 6; i >= 0; i--) begin
      r = {r[6:0], (i >= 7) ? msg[i-7] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk_rf(input resp_kind_t k, input logic [5:0] ridx,
                                         input logic [127:0] pay, input int flip);
    logic [135:0] f;
    f = '0;
    case (k)
      RESP_48: begin
        f[47:0] = {2'b00, ridx, pay[31:0], 7'h00, 1'b1};
        f[7:1]  = crc_ref(120'(f[47:8]), 40);
      end
      RESP_48_NOCRC: f[47:0] = {2'b00, 6'h3F, pay[31:0], 7'h7F, 1'b1};
      RESP_136: begin
        f      = {2'b00, 6'h3F, pay[127:8], 7'h00, 1'b1};
        f[7:1] = crc_ref(pay[127:8], 120);
      end
      default: f = '0;
    endcase
    if (flip > 0) f[flip] = ~f[flip];
    return f;
  endfunction

  task automatic wait_ncc(input string tag);
    int  n;
    bit  rv_any;
    n      = 0;
    rv_any = 1'b0;
    while (!bus.cmd_ready && n < 3 * NCC_MIN) begin
      stb();
      if (rv_seen) rv_any = 1'b1;
      n++;
    end
    check({tag, "_ncc"}, 128'(n), 128'(NCC_MIN));
    check({tag, "_ncc_rv"}, 128'(rv_any), 128'(0));
  endtask

  task automatic do_cmd(input string tag, input logic [5:0] cidx, input logic [31:0] carg,
                        input resp_kind_t kind, input logic [135:0] rfr, input bit stuck,
                        input int delay, output logic [47:0] txcap);
    logic [39:0]  hdr;
    logic [47:0]  exp_tx;
    logic [127:0] exp_data;
    logic [5:0]   exp_idx;
    logic         exp_crc, exp_eidx, exp_tmo;
    int           rlen, kstart, exp_k, k;
    bit           done, bad_oe, rv_tx;

    hdr      = {2'b01, cidx, carg};
    exp_tx   = {hdr, crc_ref(120'(hdr), 40), 1'b1};
    rlen     = (kind == RESP_136) ? 136 : 48;
    kstart   = 1 + delay;
    exp_data = '0;
    exp_idx  = '0;
    exp_crc  = 1'b0;
    exp_eidx = 1'b0;
    exp_tmo  = 1'b0;
    if (kind == RESP_NONE) exp_k = 1;
    else if (stuck) begin
      exp_k   = NCR_MAX;
      exp_tmo = 1'b1;
    end else begin
      exp_k = kstart + rlen - 1;
      if (kind == RESP_136) begin
        exp_data = {rfr[127:1], 1'b0};
        exp_idx  = 6'h3F;
        exp_crc  = CHK && (rfr[7:1] != crc_ref(rfr[127:8], 120));
      end else begin
        exp_data = {96'b0, rfr[39:8]};
        exp_idx  = (kind == RESP_48) ? rfr[45:40] : 6'h3F;
        exp_crc  = CHK && (kind == RESP_48) && (rfr[7:1] != crc_ref(120'(rfr[47:8]), 40));
        exp_eidx = CHK && (kind == RESP_48) && (rfr[45:40] != cidx);
      end
    end

    check({tag, "_rdy"}, 128'(bus.cmd_ready), 128'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = cidx;
    bus.cmd_arg   = carg;
    bus.resp_kind = kind;
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, "_rdy_drop"}, 128'(bus.cmd_ready), 128'(0));

    txcap  = '0;
    bad_oe = 1'b0;
    rv_tx  = 1'b0;
    for (int i = 0; i < 48; i++) begin
      stb();
      txcap = {txcap[46:0], cmd_o};
      if (!cmd_oe) bad_oe = 1'b1;
      if (rv_seen) rv_tx = 1'b1;
    end
    check({tag, "_tx"}, 128'(txcap), 128'(exp_tx));
    check({tag, "_oe_tx"}, 128'(bad_oe), 128'(0));
    check({tag, "_rv_tx"}, 128'(rv_tx), 128'(0));

    k    = 0;
    done = 1'b0;
    while (!done && k < NCR_MAX + 200) begin
      k++;
      if (!stuck && kind != RESP_NONE && k >= kstart && k < kstart + rlen)
        cmd_i = rfr[rlen - 1 - (k - kstart)];
      else
        cmd_i = 1'b1;
      stb();
      if (k == 1 && kind != RESP_NONE) check({tag, "_oe_turn"}, 128'(cmd_oe), 128'(0));
      if (rv_seen) done = 1'b1;
    end
    cmd_i = 1'b1;
    check({tag, "_resp_at"}, 128'(k), 128'(exp_k));
    check({tag, "_data"}, s_data, exp_data);
    check({tag, "_idx"}, 128'(s_idx), 128'(exp_idx));
    check({tag, "_err_crc"}, 128'(s_ecrc), 128'(exp_crc));
    check({tag, "_err_idx"}, 128'(s_eidx), 128'(exp_eidx));
    check({tag, "_err_tmo"}, 128'(s_etmo), 128'(exp_tmo));
    check({tag, "_pulse"}, 128'(rv_after), 128'(0));
    check({tag, "_oe_done"}, 128'(cmd_oe), 128'(1));
    check({tag, "_o_done"}, 128'(cmd_o), 128'(1));
    wait_ncc(tag);
    check({tag, "_hold"}, bus.resp_data, exp_data);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [47:0]  txc;
  resp_kind_t   rk;
  logic [5:0]   ci, ri;
  logic [31:0]  ca;
  logic [127:0] pay;
  int           fl;
  bit           st;

  initial begin
    rst           = 1'b1;
    bit_stb       = 1'b0;
    cmd_i         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_idx   = '0;
    bus.cmd_arg   = '0;
    bus.resp_kind = RESP_NONE;
    repeat (3) tick();
    check("rst_cmd_o", 128'(cmd_o), 128'(1));
    check("rst_cmd_oe", 128'(cmd_oe), 128'(0));
    check("rst_ready", 128'(bus.cmd_ready), 128'(0));
    check("rst_rv", 128'(bus.resp_valid), 128'(0));
    check("rst_data", bus.resp_data, 128'(0));
    check("rst_idx", 128'(bus.resp_idx), 128'(0));
    check("rst_errs", 128'({bus.err_crc, bus.err_idx, bus.err_tmo}), 128'(0));
    rst = 1'b0;
    tick();
    check("rst_stall", 128'(bus.cmd_ready), 128'(0));
    wait_ncc("init");

    do_cmd("cmd0", 6'd0, 32'h0, RESP_NONE, '0, 1'b0, 1, txc);
    check("cmd0_vec", 128'(txc), 128'(48'h40_00000000_95));

    do_cmd("cmd17", 6'd17, 32'h0, RESP_48, mk_rf(RESP_48, 6'd17, 128'(32'h0000_0900), 0), 1'b0, 5, txc);
    check("cmd17_vec", 128'(txc), 128'(48'h51_00000000_55));

    do_cmd("cmd1", 6'd1, 32'h40FF_8080, RESP_48_NOCRC, 136'(48'h3F_80FF8080_FF), 1'b0, 3, txc);
    do_cmd("cmd2", 6'd2, 32'h0, RESP_136,
           mk_rf(RESP_136, 6'h3F, {$urandom(), $urandom(), $urandom(), $urandom()}, 4), 1'b0, 2, txc);
    do_cmd("cmd13", 6'd13, 32'h0001_0000, RESP_48, '0, 1'b1, 1, txc);
    do_cmd("badidx", 6'd7, 32'h1234_5678, RESP_48, mk_rf(RESP_48, 6'd8, 128'(32'hA5A5_0F0F), 0), 1'b0, 1, txc);

    for (int it = 0; it < 6; it++) begin
      rk  = resp_kind_t'($urandom_range(3, 0));
      ci  = 6'($urandom_range(63, 0));
      ca  = $urandom();
      pay = {$urandom(), $urandom(), $urandom(), $urandom()};
      ri  = ci;
      fl  = 0;
      st  = ($urandom_range(5, 0) == 0);
      if ($urandom_range(2, 0) == 0) ri = ci ^ 6'($urandom_range(63, 1));
      if ($urandom_range(2, 0) == 0) fl = $urandom_range(7, 1);
      do_cmd($sformatf("rnd%0d", it), ci, ca, rk, mk_rf(rk, ri, pay, fl), st,
             $urandom_range(20, 1), txc);
    end

    // Reset in the middle of a command frame.
    bus.cmd_valid = 1'b1;
    bus.cmd_idx   = 6'd24;
    bus.cmd_arg   = 32'h0;
    bus.resp_kind = RESP_48;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) stb();
    check("mid_bit19", 128'(cmd_o), 128'(0));
    rst = 1'b1;
    tick();
    check("mid_oe", 128'(cmd_oe), 128'(0));
    check("mid_o", 128'(cmd_o), 128'(1));
    check("mid_rdy", 128'(bus.cmd_ready), 128'(0));
    check("mid_rv", 128'(bus.resp_valid), 128'(0));
    rst = 1'b0;
    wait_ncc("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
